// File: rtl/sfifo_buf.sv
// sfifo_buf: synchronous first-word-fall-through FIFO for 16-bit command words.
// The head word is driven combinationally from storage, so the consumer can
// sample dout_o while empty_o=0 and then pop it with a single rd_i pulse.
// Occupancy, almost-full and sticky overflow/underflow flags are all registered
// and update on the same edge as the pointers.
module sfifo_buf #(
  parameter int DW       = 16,
  parameter int AW       = 6,
  parameter int AFULL_TH = 56
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [DW-1:0] din_i,
  output logic          full_o,
  output logic          almost_full_o,
  input  logic          rd_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic          udf_o
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] AFULL_C = (AW + 1)'(AFULL_TH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          empty_q,  empty_d;
  logic          full_q,   full_d;
  logic          afull_q,  afull_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;
  logic          wr_ok, rd_ok;
  logic [DW-1:0] mem [DEPTH];

  // Accept decisions and next-state for pointers, occupancy and flags.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    rd_ok = rd_i & ~empty_q;
    // A write into a full FIFO is still accepted when a pop frees a slot on the same edge.
    wr_ok = wr_i & (~full_q | rd_ok);

    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      wr_ok    = 1'b0;
      rd_ok    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
      if (wr_i && !wr_ok) ovf_d = 1'b1;
      if (rd_i && empty_q) udf_d = 1'b1;
    end

    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    afull_d = (count_d >= AFULL_C);
  end

  // State register with asynchronous reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage write port.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: storage has no reset; stale words are unreachable once the pointers are cleared.
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o        = mem[rd_ptr_q[AW-1:0]];
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign count_o       = count_q;
  assign ovf_o         = ovf_q;
  assign udf_o         = udf_q;

endmodule

// File: tb/tb_sfifo_buf.sv
// tb_sfifo_buf: self-checking bench for sfifo_buf (DW=16, AW=6, AFULL_TH=56).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
module tb_sfifo_buf;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int AFTH  = 56;

  logic          clk;
  logic          rst_n;
  logic          clr, wr, rd;
  logic [DW-1:0] din;
  logic          full, afull, empty, ovf, udf;
  logic [DW-1:0] dout;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO contents as a queue plus the two sticky flags.
  logic [DW-1:0] m_q [$];
  logic          m_ovf, m_udf;

  sfifo_buf #(.DW(DW), .AW(AW), .AFULL_TH(AFTH)) dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .clr_i         (clr),
    .wr_i          (wr),
    .din_i         (din),
    .full_o        (full),
    .almost_full_o (afull),
    .rd_i          (rd),
    .dout_o        (dout),
    .empty_o       (empty),
    .count_o       (count),
    .ovf_o         (ovf),
    .udf_o         (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Apply the FIFO rules to the model for one clock cycle.
  task automatic model_step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    bit was_full, was_empty, r_ok, w_ok;
    if (c) begin
      model_reset();
      return;
    end
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    r_ok = r && !was_empty;
    w_ok = w && (!was_full || r_ok);
    if (r && was_empty) m_udf = 1'b1;
    if (w && !w_ok)     m_ovf = 1'b1;
    if (r_ok) void'(m_q.pop_front());
    if (w_ok) m_q.push_back(d);
  endtask

  // One cycle: drive inputs (caller is at a falling edge), clock, return at next falling edge.
  task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    clr = c; wr = w; rd = r; din = d;
    model_step(c, w, r, d);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
  endtask

  // Compare every output against the model.
  task automatic check_model(input string name);
    int n;
    n = m_q.size();
    check({name, ".count"}, 32'(count), 32'(n));
    check({name, ".empty"}, 32'(empty), 32'(n == 0));
    check({name, ".full"},  32'(full),  32'(n == DEPTH));
    check({name, ".afull"}, 32'(afull), 32'(n >= AFTH));
    check({name, ".ovf"},   32'(ovf),   32'(m_ovf));
    check({name, ".udf"},   32'(udf),   32'(m_udf));
    if (n != 0) check({name, ".dout"}, 32'(dout), 32'(m_q[0]));
  endtask

  typedef struct {
    logic          clr, wr, rd;
    logic [DW-1:0] din;
    logic [AW:0]   e_count;
    logic          e_empty, e_full, e_ovf, e_udf;
    logic [DW-1:0] e_dout;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Expected values after each row's clock edge, derived by hand.
    //            clr   wr    rd    din       cnt   emp   full  ovf   udf   dout
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h1234, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'hABCD, 7'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h1111, 7'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h2222, 7'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h3333, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h5A5A, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A5A};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 16'h0000, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};

    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    model_reset();
    #12;
    check("rst.count", 32'(count), 32'd0);
    check("rst.flags", {27'd0, empty, full, afull, ovf, udf}, {27'd0, 5'b10000});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty must still be high while the first write is being presented.
    wr = 1'b1; din = 16'h1234;
    #1;
    check("wr_cycle.empty", 32'(empty), 32'd1);
    wr = 1'b0;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d.state", i),
            {21'd0, count, empty, full, ovf, udf},
            {21'd0, vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_udf});
      if (!vecs[i].e_empty) check($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].e_dout));
    end

    // Fill to 64: almost_full at 56, full at 64.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'(i));
      check($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
      check($sformatf("fill%0d.afull", i), 32'(afull), 32'(i + 1 >= AFTH));
      check($sformatf("fill%0d.full", i),  32'(full),  32'(i + 1 == DEPTH));
    end
    step(1'b0, 1'b1, 1'b0, 16'hFFFF);
    check("ovf.flag",  32'(ovf),   32'd1);
    check("ovf.count", 32'(count), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d.dout", i), 32'(dout), 32'(i));
      step(1'b0, 1'b0, 1'b1, 16'h0);
    end
    check("drain.empty", 32'(empty), 32'd1);
    check("drain.ovf",   32'(ovf),   32'd1);

    // Underflow, fill to 20, then clear with a concurrent write.
    step(1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0200 + i));
    check("pre_clr.state", {21'd0, count, empty, full, ovf, udf}, {21'd0, 7'd20, 4'b0011});
    step(1'b1, 1'b1, 1'b0, 16'h7777);
    check("clr.state", {22'd0, count, empty, full, afull, ovf, udf}, {22'd0, 7'd0, 5'b10000});
    step(1'b0, 1'b1, 1'b0, 16'h5A5A);
    check("post_clr.dout", 32'(dout), 32'h5A5A);
    step(1'b1, 1'b0, 1'b0, 16'h0);

    // Full FIFO with simultaneous write and read for 10 cycles.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 16'(i));
    for (int i = 0; i < 10; i++) begin
      check($sformatf("simul%0d.dout", i), 32'(dout), 32'(i));
      step(1'b0, 1'b1, 1'b1, 16'(16'h0100 + i));
      check($sformatf("simul%0d.state", i), {22'd0, count, full, ovf}, {22'd0, 7'd64, 2'b10});
    end
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain2_%0d.dout", i), 32'(dout),
            (i < 54) ? 32'(16'h000A + i) : 32'(16'h0100 + i - 54));
      step(1'b0, 1'b0, 1'b1, 16'h0);
    end
    check_model("drain2_end");

    // Randomized traffic against the model, with fill- and drain-biased phases.
    for (int i = 0; i < 600; i++) begin
      int pw, pr;
      pw = ((i / 100) % 2 == 0) ? 75 : 35;
      pr = ((i / 100) % 2 == 0) ? 35 : 75;
      step($urandom_range(99) < 1, $urandom_range(99) < pw, $urandom_range(99) < pr,
           16'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    // Asynchronous reset mid-burst, asserted between clock edges.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'(16'h0300 + i));
    wr = 1'b1; din = 16'h0399;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.count", 32'(count), 32'd0);
    check("async_rst.flags", {27'd0, empty, full, afull, ovf, udf}, {27'd0, 5'b10000});
    wr = 1'b0; din = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 16'hBEEF);
    check("post_rst.dout", 32'(dout), 32'hBEEF);
    check_model("post_rst_wr");
    step(1'b0, 1'b0, 1'b1, 16'h0);
    check_model("post_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
